// File: rtl/exc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// exc_ctrl_seq
// Registered MEM-stage exception resolver. It finds the highest-priority cause
// (bit 0 first), maps it to a type code, selects the bad address and the
// EPC-save qualifier, samples interrupt pending, sequences the pipeline flush
// and tracks the exception level (EXL).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   excp_i          raw cause vector (bit INTR_BIT is replaced internally)
//   excp_valid      MEM slot holds a valid instruction
//   nullinst        MEM slot is a bubble; suppresses all causes
//   int_i           interrupt request levels
//   int_mask        Status.IM
//   int_ie          Status.IE
//   m_en            memory access in flight; blocks interrupt injection
//   pc, m_vaddr     candidate bad addresses
//   d_refs          delay-slot qualifier for EPC/BD save
//   int_pend        registered Cause.IP
//   exc_flag        one-cycle accept pulse
//   exc_type        registered type code
//   exc_baddr       registered bad address
//   exc_save        registered EPC/BD write enable
//   flush           pipeline flush request, FLUSH_CYC cycles long
//   exl             exception level
// -----------------------------------------------------------------------------
module exc_ctrl_seq #(
    parameter int EXC_W      = 18,
    parameter int TYPE_W     = 5,
    parameter int AW         = 32,
    parameter int NINT       = 8,
    parameter int INTR_BIT   = 1,
    parameter int ERET_BIT   = 17,
    // slice i holds the code for cause bit i (default: code = i + 1)
    parameter logic [EXC_W*TYPE_W-1:0] TYPE_MAP = {
        5'd18, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
        5'd9,  5'd8,  5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1},
    parameter logic [TYPE_W-1:0] NOEXC_TYPE = '0,
    parameter logic [EXC_W-1:0]  PC_MASK    = 18'h00005,
    parameter logic [EXC_W-1:0]  MEM_MASK   = 18'h03034,
    parameter int FLUSH_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [EXC_W-1:0]  excp_i,
    input  logic              excp_valid,
    input  logic              nullinst,
    input  logic [NINT-1:0]   int_i,
    input  logic [NINT-1:0]   int_mask,
    input  logic              int_ie,
    input  logic              m_en,
    input  logic [AW-1:0]     pc,
    input  logic [AW-1:0]     m_vaddr,
    input  logic              d_refs,
    output logic [NINT-1:0]   int_pend,
    output logic              exc_flag,
    output logic [TYPE_W-1:0] exc_type,
    output logic [AW-1:0]     exc_baddr,
    output logic              exc_save,
    output logic              flush,
    output logic              exl
);

    // state | meaning
    // IDLE  | waiting for a cause; accepts the winner of the effective vector
    // FLUSH | flush held high, counter running; new causes are ignored

    localparam int WW = (EXC_W > 1) ? $clog2(EXC_W) : 1;
    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;

    logic              intr_req;
    logic [EXC_W-1:0]  excv;
    logic [WW-1:0]     winner;
    logic [TYPE_W-1:0] win_type;
    logic [AW-1:0]     win_baddr;
    logic              win_save;
    logic              is_eret;

    always_comb begin
        intr_req = (|(int_pend & int_mask)) & int_ie & ~exl & ~m_en;
        excv = excp_i;
        excv[INTR_BIT] = intr_req;
        if (nullinst || !excp_valid)
            excv = '0;
    end

    // Scanning from the top down lets the lowest set bit be the last writer.
    always_comb begin
        winner    = '0;
        win_type  = NOEXC_TYPE;
        win_baddr = '0;
        win_save  = 1'b0;
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (excv[i]) begin
                winner   = WW'(i);
                win_type = TYPE_MAP[i*TYPE_W +: TYPE_W];
                if (PC_MASK[i]) begin
                    win_baddr = pc;
                    win_save  = 1'b0;
                end else if (MEM_MASK[i]) begin
                    win_baddr = m_vaddr;
                    win_save  = d_refs;
                end else begin
                    win_baddr = '0;
                    win_save  = d_refs;
                end
            end
        end
        // nested exception must not clobber EPC
        if (exl)
            win_save = 1'b0;
        is_eret = (|excv) && (winner == WW'(ERET_BIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            int_pend  <= '0;
            exc_flag  <= 1'b0;
            exc_type  <= NOEXC_TYPE;
            exc_baddr <= '0;
            exc_save  <= 1'b0;
            flush     <= 1'b0;
            exl       <= 1'b0;
        end else begin
            int_pend <= int_i;
            case (state)
                IDLE: begin
                    if (|excv) begin
                        exc_flag  <= 1'b1;
                        exc_type  <= win_type;
                        exc_baddr <= win_baddr;
                        exc_save  <= win_save;
                        flush     <= 1'b1;
                        cnt       <= CW'(FLUSH_CYC - 1);
                        exl       <= ~is_eret;
                        state     <= FLUSH;
                    end else begin
                        exc_flag <= 1'b0;
                    end
                end
                FLUSH: begin
                    exc_flag <= 1'b0;
                    if (cnt == '0) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
